// File: rtl/mmio_io_unit.sv
// mmio_io_unit: memory-mapped UART TX/RX buffers plus cycle and retire counters.
// MMIO_FIFO_EN selects FIFO_DEPTH-entry buffers; otherwise single-entry holding registers.

module mmio_byte_buf #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   logic do_push;
   logic do_pop;

   // A push into a full buffer is dropped even when a pop frees a slot.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   generate
      if (DEPTH == 1) begin : g_reg
         logic       vld;
         logic [7:0] data;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld <= 1'b0;
            end else if (do_push) begin
               vld <= 1'b1;
            end else if (do_pop) begin
               vld <= 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (do_push) begin
               data <= din;
            end
         end

         assign dout  = data;
         assign full  = vld;
         assign empty = ~vld;
      end else begin : g_fifo
         localparam int AW = $clog2(DEPTH);

         logic [7:0]    mem [DEPTH];
         logic [AW-1:0] wr_ptr;
         logic [AW-1:0] rd_ptr;
         logic [AW:0]   count;

         always_ff @(posedge clk) begin
            if (rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               count  <= '0;
            end else begin
               if (do_push) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               if (do_pop) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
               unique case ({do_push, do_pop})
                  2'b10:   count <= count + 1'b1;
                  2'b01:   count <= count - 1'b1;
                  default: count <= count;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (do_push) begin
               mem[wr_ptr] <= din;
            end
         end

         assign dout  = mem[rd_ptr];
         assign full  = (count == (AW+1)'(DEPTH));
         assign empty = (count == '0);
      end
   endgenerate

endmodule

module mmio_io_unit #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  mmap_sel,
   input  logic [31:0] wdata,
   input  logic        data_in_valid,
   input  logic        data_out_ready,
   input  logic        inst_retire,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

`ifdef MMIO_FIFO_EN
   localparam int BUF_DEPTH = FIFO_DEPTH;
`else
   localparam int BUF_DEPTH = 1;
   localparam int unused_depth = FIFO_DEPTH;
`endif

   localparam logic [2:0] SEL_CTRL = 3'd0;
   localparam logic [2:0] SEL_RX   = 3'd1;
   localparam logic [2:0] SEL_TX   = 3'd2;
   localparam logic [2:0] SEL_CYC  = 3'd3;
   localparam logic [2:0] SEL_INST = 3'd4;
   localparam logic [2:0] SEL_CLR  = 3'd5;

   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        tx_empty;
   logic [7:0]  tx_head;
   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic [7:0]  rx_head;
   logic [31:0] cycle_cnt;
   logic [31:0] inst_cnt;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   assign tx_push = data_in_valid & (mmap_sel == SEL_TX);
   assign tx_pop  = uart_tx_valid & uart_tx_ready;
   assign rx_push = uart_rx_valid & uart_rx_ready;
   assign rx_pop  = data_out_ready & (mmap_sel == SEL_RX);

   // Handshakes are masked during reset so no byte crosses before state clears.
   assign uart_tx_valid = ~tx_empty & ~rst;
   assign uart_tx_data  = tx_head;
   assign uart_rx_ready = ~rx_full & ~rst;

   mmio_byte_buf #(
      .DEPTH(BUF_DEPTH)
   ) u_tx_buf (
      .clk  (clk),
      .rst  (rst),
      .push (tx_push),
      .pop  (tx_pop),
      .din  (wdata[7:0]),
      .dout (tx_head),
      .full (tx_full),
      .empty(tx_empty)
   );

   mmio_byte_buf #(
      .DEPTH(BUF_DEPTH)
   ) u_rx_buf (
      .clk  (clk),
      .rst  (rst),
      .push (rx_push),
      .pop  (rx_pop),
      .din  (uart_rx_data),
      .dout (rx_head),
      .full (rx_full),
      .empty(rx_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else if (mmap_sel == SEL_CLR) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (inst_retire) begin
            inst_cnt <= inst_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         unique case (mmap_sel)
            SEL_CTRL: rdata <= {30'b0, ~rx_empty, ~tx_full};
            SEL_RX:   rdata <= rx_empty ? 32'd0 : {24'b0, rx_head};
            SEL_CYC:  rdata <= cycle_cnt;
            SEL_INST: rdata <= inst_cnt;
            default:  rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Testbench for mmio_io_unit: scoreboarded TX/RX traffic, load map and counters.
// The buffer depth model follows MMIO_FIFO_EN the same way the build does.
`timescale 1ns/1ps

module tb_mmio_io_unit;

`ifdef MMIO_FIFO_EN
   localparam int DEPTH = 8;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  mmap_sel;
   logic [31:0] wdata;
   logic        data_in_valid;
   logic        data_out_ready;
   logic        inst_retire;
   logic [31:0] rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  tx_q [$];
   logic [7:0]  rx_q [$];
   logic [31:0] exp_q [$];

   mmio_io_unit #(
      .FIFO_DEPTH(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mmap_sel      (mmap_sel),
      .wdata         (wdata),
      .data_in_valid (data_in_valid),
      .data_out_ready(data_out_ready),
      .inst_retire   (inst_retire),
      .rdata         (rdata),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      mmap_sel       = 3'd7;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b0;
      inst_retire    = 1'b0;
      uart_rx_valid  = 1'b0;
   endtask

   function automatic logic [31:0] ctrl_exp();
      return {30'b0, rx_q.size() > 0, tx_q.size() < DEPTH};
   endfunction

   task automatic test_reset();
      rst           = 1'b1;
      idle();
      wdata         = '0;
      uart_tx_ready = 1'b0;
      uart_rx_data  = '0;
      repeat (3) begin
         cyc();
         checks++;
         if (rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'd0);
         end
         checks++;
         if (uart_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx_valid got=%b exp=0", uart_tx_valid);
         end
         checks++;
         if (uart_rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_rx_ready got=%b exp=0", uart_rx_ready);
         end
      end
      rst = 1'b0;
      cyc();
      checks++;
      if (uart_rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_rx_ready got=%b exp=1", uart_rx_ready);
      end
      checks++;
      if (uart_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_tx_valid got=%b exp=0", uart_tx_valid);
      end
      mmap_sel = 3'd3;
      exp_q.push_back(32'd1);
      cyc();
      checks++;
      if (rdata !== exp_q[0]) begin
         failures++;
         $display("FAIL first_cycle_count got=%h exp=%h", rdata, exp_q[0]);
      end
      void'(exp_q.pop_front());
      idle();
   endtask

   task automatic test_tx_order();
      logic [7:0] e;
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wdata         = 32'h41 + 32'(i);
         data_in_valid = 1'b1;
         mmap_sel      = 3'd2;
         if (tx_q.size() < DEPTH) tx_q.push_back(8'(8'h41 + i));
         cyc();
      end
      idle();
      uart_tx_ready = 1'b1;
      #1;
      for (int n = 0; n < DEPTH + 2 && tx_q.size() > 0; n++) begin
         e = tx_q.pop_front();
         checks++;
         if (uart_tx_valid !== 1'b1 || uart_tx_data !== e) begin
            failures++;
            $display("FAIL tx_order got valid=%b data=%h exp data=%h",
                     uart_tx_valid, uart_tx_data, e);
         end
         cyc();
         #1;
      end
      checks++;
      if (uart_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL tx_order_empty got=%b exp=0", uart_tx_valid);
      end
      uart_tx_ready = 1'b0;
   endtask

   task automatic test_tx_overflow();
      logic [7:0] e;
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            idle();
            mmap_sel = 3'd0;
            exp_q.push_back(ctrl_exp());
            cyc();
            checks++;
            if (rdata !== exp_q[0]) begin
               failures++;
               $display("FAIL tx_full_ctrl got=%h exp=%h", rdata, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         wdata         = 32'(i);
         data_in_valid = 1'b1;
         mmap_sel      = 3'd2;
         if (tx_q.size() < DEPTH) tx_q.push_back(8'(i));
         cyc();
      end
      idle();
      uart_tx_ready = 1'b1;
      #1;
      for (int n = 0; n < DEPTH + 2 && tx_q.size() > 0; n++) begin
         e = tx_q.pop_front();
         checks++;
         if (uart_tx_valid !== 1'b1 || uart_tx_data !== e) begin
            failures++;
            $display("FAIL tx_overflow_drain got valid=%b data=%h exp data=%h",
                     uart_tx_valid, uart_tx_data, e);
         end
         cyc();
         #1;
      end
      checks++;
      if (uart_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL tx_overflow_empty got=%b exp=0", uart_tx_valid);
      end
      uart_tx_ready = 1'b0;
   endtask

   task automatic test_rx_load();
      logic [7:0] bytes [3];
      bytes[0] = 8'h5A;
      bytes[1] = 8'h00;
      bytes[2] = 8'h77;
      for (int k = 0; k < 3; k++) begin
         if (k != 1) begin
            uart_rx_data  = bytes[k];
            uart_rx_valid = 1'b1;
            if (rx_q.size() < DEPTH) rx_q.push_back(bytes[k]);
            cyc();
            uart_rx_valid = 1'b0;
         end
         mmap_sel       = 3'd1;
         data_out_ready = 1'b1;
         exp_q.push_back(rx_q.size() > 0 ? {24'b0, rx_q[0]} : 32'd0);
         if (rx_q.size() > 0) void'(rx_q.pop_front());
         cyc();
         checks++;
         if (rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL rx_load_%0d got=%h exp=%h", k, rdata, exp_q[0]);
         end
         void'(exp_q.pop_front());
         idle();
         mmap_sel = 3'd0;
         exp_q.push_back(ctrl_exp());
         cyc();
         checks++;
         if (rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL rx_ctrl_%0d got=%h exp=%h", k, rdata, exp_q[0]);
         end
         void'(exp_q.pop_front());
         idle();
      end
   endtask

   task automatic test_back_to_back();
      logic       acc;
      logic       ld;
      logic [7:0] e;
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wdata          = 32'hA0 + 32'(i);
         data_in_valid  = (i < 4);
         uart_rx_data   = 8'(8'h90 + i);
         uart_rx_valid  = 1'b1;
         ld             = (i >= 1);
         mmap_sel       = ld ? 3'd1 : 3'd2;
         data_out_ready = ld;
         #1;
         checks++;
         if (tx_q.size() > 0) begin
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== tx_q[0]) begin
               failures++;
               $display("FAIL b2b_tx_%0d got valid=%b data=%h exp data=%h",
                        i, uart_tx_valid, uart_tx_data, tx_q[0]);
            end
         end else if (uart_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tx_%0d got valid=%b exp valid=0",
                     i, uart_tx_valid);
         end
         acc = (tx_q.size() < DEPTH) && !ld && data_in_valid;
         if (tx_q.size() > 0) void'(tx_q.pop_front());
         if (acc) tx_q.push_back(8'(8'hA0 + i));
         acc = rx_q.size() < DEPTH;
         if (ld) begin
            exp_q.push_back(rx_q.size() > 0 ? {24'b0, rx_q[0]} : 32'd0);
            if (rx_q.size() > 0) void'(rx_q.pop_front());
         end
         if (acc) rx_q.push_back(8'(8'h90 + i));
         cyc();
         if (ld) begin
            checks++;
            if (rdata !== exp_q[0]) begin
               failures++;
               $display("FAIL b2b_rx_%0d got=%h exp=%h", i, rdata, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      idle();
      for (int n = 0; n < DEPTH + 2 && (rx_q.size() > 0 || tx_q.size() > 0); n++) begin
         mmap_sel       = 3'd1;
         data_out_ready = 1'b1;
         if (tx_q.size() > 0) void'(tx_q.pop_front());
         exp_q.push_back(rx_q.size() > 0 ? {24'b0, rx_q[0]} : 32'd0);
         if (rx_q.size() > 0) void'(rx_q.pop_front());
         cyc();
         checks++;
         if (rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL b2b_rx_drain got=%h exp=%h", rdata, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      idle();
      #1;
      checks++;
      if (uart_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_tx_empty got=%b exp=0", uart_tx_valid);
      end
      uart_tx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wdata         = 32'hC0 + 32'(i);
         data_in_valid = 1'b1;
         mmap_sel      = 3'd2;
         uart_rx_data  = 8'(8'hD0 + i);
         uart_rx_valid = 1'b1;
         cyc();
      end
      idle();
      #1;
      checks++;
      if (uart_tx_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre_tx_valid got=%b exp=1", uart_tx_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_handshake got tx_valid=%b rx_ready=%b exp 0 0",
                  uart_tx_valid, uart_rx_ready);
      end
      cyc();
      rst = 1'b0;
      tx_q.delete();
      rx_q.delete();
      #1;
      checks++;
      if (uart_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_tx_discard got=%b exp=0", uart_tx_valid);
      end
      mmap_sel = 3'd0;
      exp_q.push_back(ctrl_exp());
      cyc();
      checks++;
      if (rdata !== exp_q[0]) begin
         failures++;
         $display("FAIL mid_ctrl got=%h exp=%h", rdata, exp_q[0]);
      end
      void'(exp_q.pop_front());
      idle();
   endtask

   task automatic test_counters();
      logic [2:0]  sels [5];
      logic [31:0] exps [5];
      mmap_sel = 3'd5;
      cyc();
      mmap_sel = 3'd7;
      for (int i = 0; i < 10; i++) begin
         inst_retire = (i % 2 == 1) && (i < 8);
         cyc();
      end
      inst_retire = 1'b0;
      sels[0] = 3'd3; exps[0] = 32'd10;
      sels[1] = 3'd4; exps[1] = 32'd4;
      sels[2] = 3'd6; exps[2] = 32'd0;
      sels[3] = 3'd2; exps[3] = 32'd0;
      sels[4] = 3'd7; exps[4] = 32'd0;
      for (int k = 0; k < 5; k++) begin
         mmap_sel = sels[k];
         exp_q.push_back(exps[k]);
         cyc();
         checks++;
         if (rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL counter_read_sel%0d got=%h exp=%h",
                     sels[k], rdata, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      mmap_sel    = 3'd5;
      inst_retire = 1'b1;
      cyc();
      inst_retire = 1'b0;
      sels[0] = 3'd3;
      sels[1] = 3'd4;
      for (int k = 0; k < 2; k++) begin
         mmap_sel = sels[k];
         exp_q.push_back(32'd0);
         cyc();
         checks++;
         if (rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL counter_clear_sel%0d got=%h exp=%h",
                     sels[k], rdata, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_tx_order();
      test_tx_overflow();
      test_rx_load();
      test_back_to_back();
      test_reset_mid();
      test_counters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
